// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared constants for the rv32i datapath selectors.
//   SEL_IN0..SEL_IN3 : select codes for the 4:1 selectors (in_0..in_3)
//   SEL_W_4S1        : select width of a 4-input selector
//   DEFAULT_DATA_W   : default data width of the 2-bit selector
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int SEL_W_4S1      = 2;
  localparam int DEFAULT_DATA_W = 2;

  localparam logic [SEL_W_4S1-1:0] SEL_IN0 = 2'd0;
  localparam logic [SEL_W_4S1-1:0] SEL_IN1 = 2'd1;
  localparam logic [SEL_W_4S1-1:0] SEL_IN2 = 2'd2;
  localparam logic [SEL_W_4S1-1:0] SEL_IN3 = 2'd3;

endpackage

// File: rtl/selector_2b_4s1_mux4_comb.sv
// ---------------------------------------------------------------------------
// mux4_comb
// Purely combinational 4:1 select. No state.
// Ports:
//   in_0..in_3  in   DATA_W  data inputs
//   control_in  in   SEL_W   select code (SEL_IN0..SEL_IN3)
//   sel_d       out  DATA_W  selected data
// ---------------------------------------------------------------------------
module mux4_comb
  import rv32i_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SEL_W  = SEL_W_4S1        // only 2 is supported
) (
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [SEL_W-1:0]  control_in,
  output logic [DATA_W-1:0] sel_d
);

  // Every code is listed; the default only catches X/Z on control_in in
  // simulation and forces a clean zero instead of propagating X.
  always_comb begin
    sel_d = '0;
    case (control_in)
      SEL_IN0: sel_d = in_0;
      SEL_IN1: sel_d = in_1;
      SEL_IN2: sel_d = in_2;
      SEL_IN3: sel_d = in_3;
      default: sel_d = '0;
    endcase
  end

endmodule

// File: rtl/selector_2b_4s1.sv
// ---------------------------------------------------------------------------
// selector_2b_4s1
// 4-input, 2-bit selector with a registered output, used for operand,
// writeback and next-PC source selection. The select path ends on a flop,
// so consumers see a fixed one-cycle latency. There is no handshake: every
// cycle is valid and out always reflects the previous cycle's selection.
// Ports:
//   sys_clk     in   1       clock, rising edge
//   sys_rst_n   in   1       asynchronous active-low reset (clears out)
//   in_0..in_3  in   DATA_W  data inputs
//   control_in  in   SEL_W   select code
//   out         out  DATA_W  registered selected data
// ---------------------------------------------------------------------------
module selector_2b_4s1
  import rv32i_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SEL_W  = SEL_W_4S1        // only 2 is supported
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [SEL_W-1:0]  control_in,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] w_sel_d;
  logic [DATA_W-1:0] r_out;

  mux4_comb #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_mux4_comb (
    .in_0       (in_0),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .control_in (control_in),
    .sel_d      (w_sel_d)
  );

  // Reset clears immediately; release is picked up by the next rising edge,
  // which loads whatever is selected at that moment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_sel_d;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_selector_2b_4s1.sv
module tb_selector_2b_4s1;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] in_0, in_1, in_2, in_3;
  logic [1:0] control_in;
  logic [1:0] dut_out;

  int n_checks;
  int n_fail;

  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0] i0;
    logic [1:0] i1;
    logic [1:0] i2;
    logic [1:0] i3;
    logic [1:0] ctl;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[10];

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  selector_2b_4s1 dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_0       (in_0),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .control_in (control_in),
    .out        (dut_out)
  );

  // reference: selection is just indexing the inputs by the select code
  function automatic logic [1:0] ref_mux(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c, input logic [1:0] d,
                                         input logic [1:0] sel);
    logic [1:0] arr[4];
    arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = d;
    return arr[sel];
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [1:0] d, input logic [1:0] sel);
    in_0 = a; in_1 = b; in_2 = c; in_3 = d; control_in = sel;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // ---- reset held: out stays 0 regardless of inputs/clock
    sys_rst_n = 1'b0;
    drive(2'b11, 2'b11, 2'b11, 2'b11, 2'd2);
    #1;
    check("reset_initial", dut_out, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", dut_out, 2'b00);
    end
    sys_rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", dut_out, 2'b00);
    tick();
    check("reset_release_first_edge", dut_out, 2'b11);

    // ---- table-driven vectors: output appears one edge after drive
    vecs[0] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'd0, 2'b00};
    vecs[1] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'd1, 2'b01};
    vecs[2] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'd2, 2'b10};
    vecs[3] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'd3, 2'b11};
    vecs[4] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'd0, 2'b11};
    vecs[5] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'd3, 2'b00};
    vecs[6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'd1, 2'b11};
    vecs[7] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'd2, 2'b00};
    vecs[8] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'd2, 2'b11};
    vecs[9] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'd0, 2'b01};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].i3, vecs[i].ctl);
      tick();
      check($sformatf("table[%0d]", i), dut_out, vecs[i].exp);
    end

    // ---- latency: a data change between edges is not visible until the edge
    drive(2'b00, 2'b01, 2'b10, 2'b11, 2'd1);
    tick();
    check("latency_before", dut_out, 2'b01);
    in_1 = 2'b10;
    #2;
    check("latency_no_comb_path", dut_out, 2'b01);
    tick();
    check("latency_after_edge", dut_out, 2'b10);

    // ---- simultaneous change of select and data
    drive(2'b00, 2'b01, 2'b10, 2'b00, 2'd0);
    tick();
    check("simul_pre", dut_out, 2'b00);
    control_in = 2'd3;
    in_3       = 2'b01;
    tick();
    check("simul_change", dut_out, 2'b01);

    // ---- asynchronous reset mid-run
    drive(2'b00, 2'b01, 2'b10, 2'b11, 2'd3);
    tick();
    check("async_pre", dut_out, 2'b11);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_clear_no_edge", dut_out, 2'b00);
    tick();
    check("async_hold", dut_out, 2'b00);
    #2;
    sys_rst_n = 1'b1;
    #1;
    check("async_release_no_edge", dut_out, 2'b00);
    tick();
    check("async_release_edge", dut_out, 2'b11);

    // ---- random stimulus against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] a, b, c, d, s;
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      drive(a, b, c, d, s);
      exp_q.push_back(ref_mux(a, b, c, d, s));
      tick();
      check("random", dut_out, exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
